ps2_host_transmitter: RTL and testbench

//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard

---
 rtl/ps2_host_transmitter.sv | 259 +++++++++++++++++++++++++
 tb/tb_ps2_host_transmitter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_transmitter.sv
// ps2_host_transmitter
// Sends one command byte from the host to a PS/2 device over the shared
// PS2_CLK / PS2_DAT lines. The lines are open-drain. The top level builds them
// as PS2_x = x_oe ? 1'b0 : 1'bz.
// A transfer runs in this order:
//   1. Hold the clock line low (inhibit).
//   2. Pull data low to give the start bit.
//   3. Release the clock and let the device clock out eight data bits (LSB
//      first), odd parity and stop.
//   4. Sample the device acknowledge bit.
//   5. Wait for both lines to go idle.
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   send, cmd[7:0]        transfer request and byte (sampled only when idle)
//   ps2_clk_in/dat_in     raw line levels (asynchronous)
//   ps2_clk_oe/dat_oe     1 = pull the corresponding line low
//   busy                  transfer in progress
//   done                  one-cycle pulse at the end of every accepted transfer
//   ack_ok, error         result of the last transfer, held until next send
module ps2_host_transmitter #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int START_TIMEOUT  = 750000,
    parameter int XFER_TIMEOUT   = 100000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       send,
    input  logic [7:0] cmd,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_ok,
    output logic       error
);

    localparam int MAX_AB  = (INHIBIT_CYCLES > START_TIMEOUT) ? INHIBIT_CYCLES : START_TIMEOUT;
    localparam int MAX_CNT = (MAX_AB > XFER_TIMEOUT) ? MAX_AB : XFER_TIMEOUT;
    localparam int TW      = $clog2(MAX_CNT + 1);

    localparam logic [TW-1:0] TIMER_ZERO   = {TW{1'b0}};
    localparam logic [TW-1:0] TIMER_ONE    = {{(TW-1){1'b0}}, 1'b1};
    localparam logic [TW-1:0] INHIBIT_LAST = TW'(INHIBIT_CYCLES - 32'sd1);
    localparam logic [TW-1:0] START_LAST   = TW'(START_TIMEOUT - 32'sd1);
    localparam logic [TW-1:0] XFER_LAST    = TW'(XFER_TIMEOUT - 32'sd1);

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_INHIBIT     = 3'd1,
        ST_REQ         = 3'd2,
        ST_RELEASE_CLK = 3'd3,
        ST_SHIFT       = 3'd4,
        ST_WAIT_IDLE   = 3'd5,
        ST_DONE        = 3'd6,
        ST_TIMEOUT     = 3'd7
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    clk_sync_q, clk_sync_d;
    logic [1:0]    dat_sync_q, dat_sync_d;
    logic          clk_prev_q, clk_prev_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    edge_q, edge_d;
    logic [7:0]    cmd_q, cmd_d;
    logic          parity_q, parity_d;
    logic          clk_oe_q, clk_oe_d;
    logic          dat_oe_q, dat_oe_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          ack_ok_q, ack_ok_d;
    logic          error_q, error_d;

    logic          clk_s, dat_s, fall_s;
    logic [3:0]    edge_m1_s;
    logic [2:0]    bit_idx_s;

    assign clk_s  = clk_sync_q[1];
    assign dat_s  = dat_sync_q[1];
    assign fall_s = clk_prev_q & ~clk_s;

    // State register: every flop, with a synchronous reset that releases both lines
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            clk_sync_q <= 2'b11;   // idle lines read high, so no false fall leaves reset
            dat_sync_q <= 2'b11;
            clk_prev_q <= 1'b1;
            timer_q    <= TIMER_ZERO;
            edge_q     <= 4'd0;
            cmd_q      <= 8'h00;
            parity_q   <= 1'b0;
            clk_oe_q   <= 1'b0;
            dat_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ack_ok_q   <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_sync_q <= clk_sync_d;
            dat_sync_q <= dat_sync_d;
            clk_prev_q <= clk_prev_d;
            timer_q    <= timer_d;
            edge_q     <= edge_d;
            cmd_q      <= cmd_d;
            parity_q   <= parity_d;
            clk_oe_q   <= clk_oe_d;
            dat_oe_q   <= dat_oe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ack_ok_q   <= ack_ok_d;
            error_q    <= error_d;
        end
    end

    // Next state: synchronizers, sequencing, the edge counter and the shared timeout timer
    always_comb begin
        clk_sync_d = {clk_sync_q[0], ps2_clk_in};
        dat_sync_d = {dat_sync_q[0], ps2_dat_in};
        clk_prev_d = clk_s;
        state_d    = state_q;
        timer_d    = timer_q;
        edge_d     = edge_q;
        cmd_d      = cmd_q;
        parity_d   = parity_q;
        case (state_q)
            ST_IDLE: begin
                timer_d = TIMER_ZERO;
                if (send) begin
                    state_d  = ST_INHIBIT;
                    cmd_d    = cmd;
                    parity_d = ~^cmd;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_INHIBIT: begin
                if (timer_q >= INHIBIT_LAST) begin
                    state_d = ST_REQ;
                    timer_d = TIMER_ZERO;
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end
            ST_REQ: begin
                state_d = ST_RELEASE_CLK;
                timer_d = TIMER_ZERO;
                edge_d  = 4'd0;
            end
            ST_RELEASE_CLK: begin
                if (fall_s) begin
                    state_d = ST_SHIFT;
                    edge_d  = 4'd1;
                    timer_d = TIMER_ZERO;   // transfer timer starts at the first fall
                end else if (timer_q >= START_LAST) begin
                    state_d = ST_TIMEOUT;
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end
            ST_SHIFT: begin
                // A fall wins over a coincident expiry. The >= compare still fires on the next cycle.
                if (fall_s) begin
                    edge_d  = (edge_q >= 4'd11) ? 4'd11 : (edge_q + 4'd1);
                    timer_d = timer_q + TIMER_ONE;
                    if (edge_q == 4'd10) begin
                        state_d = ST_WAIT_IDLE;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end else if (timer_q >= XFER_LAST) begin
                    state_d = ST_TIMEOUT;
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end
            ST_WAIT_IDLE: begin
                if (clk_s && dat_s) begin
                    state_d = ST_DONE;
                end else if (timer_q >= XFER_LAST) begin
                    state_d = ST_TIMEOUT;
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end
            ST_DONE:    state_d = ST_IDLE;   // a send seen here is deliberately dropped
            ST_TIMEOUT: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Outputs: computed from the next state so the registered outputs line up with the state
    always_comb begin
        clk_oe_d  = 1'b0;
        dat_oe_d  = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        ack_ok_d  = ack_ok_q;
        error_d   = error_q;
        edge_m1_s = edge_d - 4'd1;
        bit_idx_s = edge_m1_s[2:0];
        case (state_d)
            ST_INHIBIT: begin
                clk_oe_d = 1'b1;
                busy_d   = 1'b1;
            end
            ST_REQ: begin
                clk_oe_d = 1'b1;
                dat_oe_d = 1'b1;
                busy_d   = 1'b1;
            end
            ST_RELEASE_CLK: begin
                dat_oe_d = 1'b1;
                busy_d   = 1'b1;
            end
            ST_SHIFT: begin
                busy_d = 1'b1;
                // Present the next bit right after each device fall. dat_oe is the inverted bit value.
                if (fall_s) begin
                    if (edge_d <= 4'd8) begin
                        dat_oe_d = ~cmd_q[bit_idx_s];
                    end else if (edge_d == 4'd9) begin
                        dat_oe_d = ~parity_q;
                    end else begin
                        dat_oe_d = 1'b0;
                    end
                end else begin
                    dat_oe_d = dat_oe_q;
                end
            end
            ST_WAIT_IDLE: busy_d = 1'b1;
            ST_DONE:      done_d = 1'b1;
            ST_TIMEOUT:   done_d = 1'b1;
            ST_IDLE:      busy_d = 1'b0;
            default:      busy_d = 1'b0;
        endcase
        if (state_q == ST_IDLE && send) begin
            ack_ok_d = 1'b0;
            error_d  = 1'b0;
        end else if (state_d == ST_TIMEOUT) begin
            ack_ok_d = 1'b0;
            error_d  = 1'b1;
        end else if (state_q == ST_SHIFT && state_d == ST_WAIT_IDLE) begin
            ack_ok_d = ~dat_s;   // device pulls data low on the 11th clock to acknowledge
        end else begin
            ack_ok_d = ack_ok_q;
        end
    end

    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign ack_ok     = ack_ok_q;
    assign error      = error_q;

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// tb_ps2_host_transmitter
// Directed bench for ps2_host_transmitter.
// A small device model releases and pulls the open-drain lines. It clocks at
// 40 cycles per half-period and samples the data line on each rising clock edge.
// Frames are recorded as bits[0]=start, bits[8:1]=byte, bits[9]=parity,
// bits[10]=stop.
module tb_ps2_host_transmitter;

    logic       clock = 1'b0;
    logic       reset;
    logic       send;
    logic [7:0] cmd;
    logic       ps2_clk_in, ps2_dat_in;
    logic       ps2_clk_oe, ps2_dat_oe, busy, done, ack_ok, error;
    logic       dev_clk_rel = 1'b1;
    logic       dev_dat_low = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    assign ps2_clk_in = ~ps2_clk_oe & dev_clk_rel;
    assign ps2_dat_in = ~ps2_dat_oe & ~dev_dat_low;

    always #5 clock = ~clock;

    ps2_host_transmitter #(
        .INHIBIT_CYCLES(20),
        .START_TIMEOUT (200),
        .XFER_TIMEOUT  (2000)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .send      (send),
        .cmd       (cmd),
        .ps2_clk_in(ps2_clk_in),
        .ps2_dat_in(ps2_dat_in),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_dat_oe(ps2_dat_oe),
        .busy      (busy),
        .done      (done),
        .ack_ok    (ack_ok),
        .error     (error)
    );

    // Count done pulses, sampled away from the active edge.
    always @(negedge clock) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_send(input logic [7:0] c);
        @(negedge clock);
        cmd  = c;
        send = 1'b1;
        @(negedge clock);
        send = 1'b0;
    endtask

    // Device side of one transfer.
    // If nfalls < 11 the model stops 10 cycles after that fall and leaves the clock held low.
    task automatic device_xfer(input int nfalls, input bit do_ack,
                               output logic [10:0] bits, output int inh, output int lat1);
        int   guard;
        logic prev_oe;
        bits  = 11'd0;
        inh   = 0;
        lat1  = 0;
        guard = 0;
        while (ps2_clk_oe !== 1'b1 && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        while (ps2_clk_oe === 1'b1 && guard < 1000) begin
            inh++;
            @(negedge clock);
            guard++;
        end
        repeat (30) @(negedge clock);
        bits[0] = ps2_dat_in;
        for (int i = 1; i <= nfalls; i++) begin
            dev_clk_rel = 1'b0;
            if (i == nfalls && i < 11) begin
                repeat (10) @(negedge clock);
                break;
            end
            if (i == 1) begin
                prev_oe = ps2_dat_oe;
                while (ps2_dat_oe === prev_oe && lat1 < 20) begin
                    @(negedge clock);
                    lat1++;
                end
                repeat (40 - lat1) @(negedge clock);
            end else begin
                repeat (40) @(negedge clock);
            end
            if (i <= 10) begin
                dev_clk_rel = 1'b1;
                repeat (20) @(negedge clock);
                bits[i] = ps2_dat_in;
                if (i == 10 && do_ack) dev_dat_low = 1'b1;
                repeat (20) @(negedge clock);
            end else begin
                dev_clk_rel = 1'b1;
                dev_dat_low = 1'b0;
            end
        end
    endtask

    task automatic wait_done(output bit found, output logic busy_prev, output logic busy_at,
                             output logic ack_at, output logic err_at);
        int g;
        g         = 0;
        found     = 1'b0;
        busy_prev = busy;
        busy_at   = 1'bx;
        ack_at    = 1'bx;
        err_at    = 1'bx;
        while (!found && g < 3000) begin
            if (done === 1'b1) begin
                found   = 1'b1;
                busy_at = busy;
                ack_at  = ack_ok;
                err_at  = error;
            end else begin
                busy_prev = busy;
                @(negedge clock);
                g++;
            end
        end
    endtask

    initial begin
        logic [10:0] bits;
        int          inh, lat, d0, cnt;
        bit          found, busy_seen;
        logic        bp, ba, aa, ea;

        reset = 1'b1;
        send  = 1'b0;
        cmd   = 8'h00;
        repeat (3) @(negedge clock);
        chk("rst_clk_oe", ps2_clk_oe, 0);
        chk("rst_dat_oe", ps2_dat_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ack_ok", ack_ok, 0);
        chk("rst_error", error, 0);
        reset = 1'b0;
        repeat (5) @(negedge clock);

        // Test 1: 0xED acknowledged. Clock held low for 20 inhibit cycles + 1 request cycle.
        d0 = done_cnt;
        do_send(8'hED);
        device_xfer(11, 1'b1, bits, inh, lat);
        chk("t1_inhibit_len", inh, 21);
        chk("t1_line_latency", lat, 3);
        chk("t1_frame", bits, 11'b1_1_11101101_0);
        wait_done(found, bp, ba, aa, ea);
        chk("t1_done_seen", found, 1);
        chk("t1_busy_before", bp, 1);
        chk("t1_busy_at_done", ba, 0);
        chk("t1_ack_ok", aa, 1);
        chk("t1_error", ea, 0);
        repeat (30) @(negedge clock);
        chk("t1_one_done", done_cnt - d0, 1);
        chk("t1_ack_held", ack_ok, 1);

        // Test 2: parity for 0x01 (0) and 0x00 (1).
        do_send(8'h01);
        device_xfer(11, 1'b1, bits, inh, lat);
        chk("t2a_frame", bits, 11'b1_0_00000001_0);
        wait_done(found, bp, ba, aa, ea);
        chk("t2a_done_seen", found, 1);
        chk("t2a_ack_ok", aa, 1);
        repeat (20) @(negedge clock);
        do_send(8'h00);
        device_xfer(11, 1'b1, bits, inh, lat);
        chk("t2b_frame", bits, 11'b1_1_00000000_0);
        wait_done(found, bp, ba, aa, ea);
        chk("t2b_done_seen", found, 1);
        chk("t2b_ack_ok", aa, 1);
        chk("t2b_error", ea, 0);
        repeat (20) @(negedge clock);

        // Test 3: the device never clocks, so the start timeout fires 200 cycles after clock release.
        do_send(8'hED);
        cnt = 0;
        while (ps2_clk_oe === 1'b1 && cnt < 100) begin
            @(negedge clock);
            cnt++;
        end
        cnt = 0;
        while (done !== 1'b1 && cnt < 400) begin
            @(negedge clock);
            cnt++;
        end
        chk("t3_timeout_cycles", cnt, 200);
        chk("t3_done", done, 1);
        chk("t3_error", error, 1);
        chk("t3_ack_ok", ack_ok, 0);
        chk("t3_clk_oe", ps2_clk_oe, 0);
        chk("t3_dat_oe", ps2_dat_oe, 0);
        chk("t3_busy", busy, 0);
        repeat (20) @(negedge clock);

        // Test 4: NACK. The data line stays high on the 11th clock.
        do_send(8'hFF);
        device_xfer(11, 1'b0, bits, inh, lat);
        chk("t4_frame", bits, 11'b1_1_11111111_0);
        wait_done(found, bp, ba, aa, ea);
        chk("t4_done_seen", found, 1);
        chk("t4_ack_ok", aa, 0);
        chk("t4_error", ea, 0);
        repeat (20) @(negedge clock);

        // Test 5: reset after the 4th fall. 0xF4 bit3 = 0, so data is being pulled at that point.
        d0 = done_cnt;
        do_send(8'hF4);
        device_xfer(4, 1'b1, bits, inh, lat);
        chk("t5_busy_mid", busy, 1);
        chk("t5_dat_oe_mid", ps2_dat_oe, 1);
        reset = 1'b1;
        @(negedge clock);
        chk("t5_clk_oe", ps2_clk_oe, 0);
        chk("t5_dat_oe", ps2_dat_oe, 0);
        chk("t5_busy", busy, 0);
        reset       = 1'b0;
        dev_clk_rel = 1'b1;
        repeat (30) @(negedge clock);
        chk("t5_no_done", done_cnt - d0, 0);
        do_send(8'h01);
        device_xfer(11, 1'b1, bits, inh, lat);
        chk("t5_after_frame", bits, 11'b1_0_00000001_0);
        wait_done(found, bp, ba, aa, ea);
        chk("t5_after_ack", aa, 1);
        repeat (20) @(negedge clock);

        // Test 6: send is held through the transfer and cmd changes after acceptance.
        d0 = done_cnt;
        @(negedge clock);
        cmd  = 8'hF4;
        send = 1'b1;
        @(negedge clock);
        cmd = 8'h00;
        device_xfer(11, 1'b1, bits, inh, lat);
        chk("t6_frame", bits, 11'b1_0_11110100_0);
        wait_done(found, bp, ba, aa, ea);
        chk("t6_done_seen", found, 1);
        @(posedge clock);   // send is still high at the edge that ends the DONE cycle
        #1 send = 1'b0;
        busy_seen = 1'b0;
        repeat (60) begin
            @(negedge clock);
            if (busy !== 1'b0 || ps2_clk_oe !== 1'b0) busy_seen = 1'b1;
        end
        chk("t6_no_restart", busy_seen, 0);
        chk("t6_one_done", done_cnt - d0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
